// File: rtl/bullet_engine.sv
// Two-tank bullet pool: spawns on fire requests in IDLE and moves one slot per cycle after each frame tick.
// Optional per-bullet lifetime countdown is enabled with `define BULLET_LIFETIME_EN.
module bullet_engine #(
    parameter int SPEED    = 4,
    parameter int LIFETIME = 31
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic                   frame_tick,
    input  logic [9:0]             tank1_x,
    input  logic [9:0]             tank1_y,
    input  logic [9:0]             tank2_x,
    input  logic [9:0]             tank2_y,
    input  logic [2:0]             turret1_direction,
    input  logic [2:0]             turret2_direction,
    input  logic [1:0]             fire_req,
    output logic [1:0]             fire_ack,
    output logic [1:0]             fire_drop,
    input  logic [15:0]            clear_mask,
    output logic [1:0][7:0][31:0]  bullet_array,
    output logic                   busy
);

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  slot_cnt, slot_cnt_nxt;
    logic [1:0]  armed;

    logic [1:0][9:0]  tank_x, tank_y;
    logic [1:0][2:0]  turret_dir;
    logic [1:0][2:0]  free_idx;
    logic [1:0]       has_free;
    logic [1:0]       fire_go;
    logic [1:0][31:0] spawn_word;
    logic [4:0]       life_init;

    logic               cur_vld;
    logic [2:0]         cur_dir;
    logic [9:0]         cur_x, cur_y;
    logic [4:0]         life_nxt;
    logic               expire;
    logic signed [10:0] dx, dy, nx, ny;
    logic               off_screen;
    logic [31:0]        upd_word;

    assign tank_x     = {tank2_x, tank1_x};
    assign tank_y     = {tank2_y, tank1_y};
    assign turret_dir = {turret2_direction, turret1_direction};
    assign busy       = (state == UPDATE);

    always_comb begin
        state_nxt    = state;
        slot_cnt_nxt = slot_cnt;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_nxt    = UPDATE;
                    slot_cnt_nxt = 4'd0;
                end
            end
            UPDATE: begin
                slot_cnt_nxt = slot_cnt + 4'd1;
                if (slot_cnt == 4'd15) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef BULLET_LIFETIME_EN
    assign life_init = 5'(LIFETIME);
`else
    assign life_init = 5'd0;
`endif

    // Lowest-index free slot per tank; a request is served once, then waits for fire_req to drop.
    always_comb begin
        for (int t = 0; t < 2; t++) begin
            has_free[t] = 1'b0;
            free_idx[t] = 3'd0;
            for (int s = 7; s >= 0; s--) begin
                if (!bullet_array[t][s][0]) begin
                    has_free[t] = 1'b1;
                    free_idx[t] = 3'(s);
                end
            end
            fire_go[t]    = !Reset && (state == IDLE) && fire_req[t] && armed[t];
            spawn_word[t] = {3'b000, tank_y[t] + 10'd16, tank_x[t] + 10'd16,
                             life_init, turret_dir[t], 1'b1};
        end
    end

    assign fire_ack  = fire_go & has_free;
    assign fire_drop = fire_go & ~has_free;

    assign cur_vld = bullet_array[slot_cnt[3]][slot_cnt[2:0]][0];
    assign cur_dir = bullet_array[slot_cnt[3]][slot_cnt[2:0]][3:1];
    assign cur_x   = bullet_array[slot_cnt[3]][slot_cnt[2:0]][18:9];
    assign cur_y   = bullet_array[slot_cnt[3]][slot_cnt[2:0]][28:19];

`ifdef BULLET_LIFETIME_EN
    logic [4:0] cur_life;
    assign cur_life = bullet_array[slot_cnt[3]][slot_cnt[2:0]][8:4];
    assign life_nxt = cur_life - 5'd1;
    assign expire   = (cur_life == 5'd1);
`else
    assign life_nxt = 5'd0;
    assign expire   = 1'b0;
`endif

    // Direction 0 is up, stepping clockwise by 45 degrees.
    always_comb begin
        dx = 11'sd0;
        dy = 11'sd0;
        case (cur_dir)
            3'd0: dy = -11'(SPEED);
            3'd1: begin dx =  11'(SPEED); dy = -11'(SPEED); end
            3'd2: dx =  11'(SPEED);
            3'd3: begin dx =  11'(SPEED); dy =  11'(SPEED); end
            3'd4: dy =  11'(SPEED);
            3'd5: begin dx = -11'(SPEED); dy =  11'(SPEED); end
            3'd6: dx = -11'(SPEED);
            default: begin dx = -11'(SPEED); dy = -11'(SPEED); end
        endcase
        nx = $signed({1'b0, cur_x}) + dx;
        ny = $signed({1'b0, cur_y}) + dy;
        off_screen = (nx < 11'sd0) || (nx > 11'sd639) || (ny < 11'sd0) || (ny > 11'sd479);
        if (!cur_vld)
            upd_word = bullet_array[slot_cnt[3]][slot_cnt[2:0]];
        else if (off_screen || expire)
            upd_word = 32'd0;
        else
            upd_word = {3'b000, ny[9:0], nx[9:0], life_nxt, cur_dir, 1'b1};
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            slot_cnt     <= 4'd0;
            armed        <= 2'b11;
            bullet_array <= '0;
        end else begin
            state    <= state_nxt;
            slot_cnt <= slot_cnt_nxt;
            for (int t = 0; t < 2; t++) begin
                if (fire_ack[t] || fire_drop[t])
                    armed[t] <= 1'b0;
                else if (!fire_req[t])
                    armed[t] <= 1'b1;
                for (int s = 0; s < 8; s++) begin
                    if (clear_mask[8*t+s])
                        bullet_array[t][s] <= 32'd0;
                    else if (fire_ack[t] && (free_idx[t] == 3'(s)))
                        bullet_array[t][s] <= spawn_word[t];
                    else if ((state == UPDATE) && (slot_cnt == 4'(8*t+s)))
                        bullet_array[t][s] <= upd_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine: spawn, movement, pool limits, timing and clear/reset behaviour.
module tb_bullet_engine;

    logic                  CLK = 1'b0;
    logic                  Reset;
    logic                  frame_tick;
    logic [9:0]            tank1_x, tank1_y, tank2_x, tank2_y;
    logic [2:0]            turret1_direction, turret2_direction;
    logic [1:0]            fire_req;
    logic [1:0]            fire_ack, fire_drop;
    logic [15:0]           clear_mask;
    logic [1:0][7:0][31:0] bullet_array;
    logic                  busy;

    int total = 0;
    int bad   = 0;

`ifdef BULLET_LIFETIME_EN
    localparam logic [4:0] L0 = 5'd3;
    localparam logic [4:0] L1 = 5'd2;
`else
    localparam logic [4:0] L0 = 5'd0;
    localparam logic [4:0] L1 = 5'd0;
`endif

    bullet_engine #(.SPEED(4), .LIFETIME(3)) dut (
        .CLK(CLK), .Reset(Reset), .frame_tick(frame_tick),
        .tank1_x(tank1_x), .tank1_y(tank1_y), .tank2_x(tank2_x), .tank2_y(tank2_y),
        .turret1_direction(turret1_direction), .turret2_direction(turret2_direction),
        .fire_req(fire_req), .fire_ack(fire_ack), .fire_drop(fire_drop),
        .clear_mask(clear_mask), .bullet_array(bullet_array), .busy(busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk(input logic [9:0] x, input logic [9:0] y,
                                       input logic [2:0] d, input logic [4:0] l);
        return {3'b000, y, x, l, d, 1'b1};
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b1; fire_req = 2'b00; frame_tick = 1'b0; clear_mask = 16'd0;
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
    endtask

    task automatic fire(input logic [1:0] m, output logic [1:0] a, output logic [1:0] d);
        @(negedge CLK);
        fire_req = m;
        #1;
        a = fire_ack;
        d = fire_drop;
        @(negedge CLK);
        fire_req = 2'b00;
        @(negedge CLK);
    endtask

    task automatic tick(output int n);
        @(negedge CLK);
        frame_tick = 1'b1;
        @(negedge CLK);
        frame_tick = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        Reset = 1'b1;
        fire_req = 2'b01;
        #1;
        total++;
        if (bullet_array !== '0 || busy !== 1'b0 || fire_ack !== 2'b00 || fire_drop !== 2'b00) begin
            bad++;
            $display("FAIL reset_state: busy=%b ack=%b drop=%b array_nonzero=%b want 0/00/00/0",
                     busy, fire_ack, fire_drop, |bullet_array);
        end
        fire_req = 2'b00;
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        total++;
        if (busy !== 1'b0 || bullet_array !== '0) begin
            bad++;
            $display("FAIL reset_release: busy=%b array_nonzero=%b want 0 0", busy, |bullet_array);
        end
    endtask

    task automatic test_fire_basic();
        logic [1:0] a, d;
        int n;
        do_reset();
        tank1_x = 10'd100; tank1_y = 10'd200; turret1_direction = 3'd2;
        fire(2'b01, a, d);
        total++;
        if (a !== 2'b01 || d !== 2'b00) begin
            bad++;
            $display("FAIL spawn_ack: ack=%b drop=%b want 01 00", a, d);
        end
        total++;
        if (bullet_array[0][0] !== mk(10'd116, 10'd216, 3'd2, L0)) begin
            bad++;
            $display("FAIL spawn_slot0: got %h want %h", bullet_array[0][0], mk(10'd116, 10'd216, 3'd2, L0));
        end
        tick(n);
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL busy_len_basic: got %0d want 16", n);
        end
        total++;
        if (bullet_array[0][0] !== mk(10'd120, 10'd216, 3'd2, L1)) begin
            bad++;
            $display("FAIL move_right: got %h want %h", bullet_array[0][0], mk(10'd120, 10'd216, 3'd2, L1));
        end
    endtask

    task automatic test_pool_full();
        logic [1:0] a, d;
        logic [31:0] exp_w [8];
        logic d1, d2, a1;
        do_reset();
        tank1_y = 10'd50; turret1_direction = 3'd4;
        for (int i = 0; i < 8; i++) begin
            tank1_x = 10'(10 * i);
            exp_w[i] = mk(10'(10 * i + 16), 10'd66, 3'd4, L0);
            fire(2'b01, a, d);
            total++;
            if (a !== 2'b01) begin
                bad++;
                $display("FAIL pool_fill_ack%0d: got %b want 01", i, a);
            end
        end
        tank1_x = 10'd300;
        @(negedge CLK);
        fire_req = 2'b01;
        #1;
        d1 = fire_drop[0];
        a1 = fire_ack[0];
        @(negedge CLK);
        #1;
        d2 = fire_drop[0];
        @(negedge CLK);
        fire_req = 2'b00;
        @(negedge CLK);
        total++;
        if (d1 !== 1'b1 || a1 !== 1'b0 || d2 !== 1'b0) begin
            bad++;
            $display("FAIL pool_drop: drop=%b ack=%b drop_held=%b want 1 0 0", d1, a1, d2);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bullet_array[0][i] !== exp_w[i]) begin
                bad++;
                $display("FAIL pool_slot%0d: got %h want %h", i, bullet_array[0][i], exp_w[i]);
            end
        end
    endtask

    task automatic test_offscreen();
        logic [1:0] a, d;
        int n;
        do_reset();
        tank1_x = 10'd621; tank1_y = 10'd100; turret1_direction = 3'd2;
        tank2_x = 10'd1010; tank2_y = 10'd100; turret2_direction = 3'd6;
        fire(2'b11, a, d);
        total++;
        if (bullet_array[0][0] !== mk(10'd637, 10'd116, 3'd2, L0) ||
            bullet_array[1][0] !== mk(10'd2, 10'd116, 3'd6, L0)) begin
            bad++;
            $display("FAIL edge_spawn: got %h %h want %h %h", bullet_array[0][0], bullet_array[1][0],
                     mk(10'd637, 10'd116, 3'd2, L0), mk(10'd2, 10'd116, 3'd6, L0));
        end
        tick(n);
        total++;
        if (bullet_array[0][0] !== 32'd0 || bullet_array[1][0] !== 32'd0) begin
            bad++;
            $display("FAIL off_screen: got %h %h want 0 0", bullet_array[0][0], bullet_array[1][0]);
        end
    endtask

    task automatic test_both_tanks();
        logic [1:0] a, d;
        int n;
        do_reset();
        tank1_x = 10'd300; tank1_y = 10'd100; turret1_direction = 3'd7;
        tank2_x = 10'd50;  tank2_y = 10'd60;  turret2_direction = 3'd3;
        fire(2'b11, a, d);
        total++;
        if (a !== 2'b11 || d !== 2'b00) begin
            bad++;
            $display("FAIL both_ack: ack=%b drop=%b want 11 00", a, d);
        end
        tick(n);
        total++;
        if (bullet_array[0][0] !== mk(10'd312, 10'd112, 3'd7, L1) ||
            bullet_array[1][0] !== mk(10'd70, 10'd80, 3'd3, L1)) begin
            bad++;
            $display("FAIL diag_move: got %h %h want %h %h", bullet_array[0][0], bullet_array[1][0],
                     mk(10'd312, 10'd112, 3'd7, L1), mk(10'd70, 10'd80, 3'd3, L1));
        end
    endtask

    task automatic test_fire_during_update();
        int n;
        logic early, ack_now, busy_after;
        do_reset();
        tank2_x = 10'd0; tank2_y = 10'd0; turret2_direction = 3'd4;
        @(negedge CLK);
        frame_tick = 1'b1;
        @(negedge CLK);
        frame_tick = 1'b0;
        n = 0;
        early = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == 3) begin
                fire_req = 2'b10;
                frame_tick = 1'b1;
            end
            if (n == 4) frame_tick = 1'b0;
            #1;
            if (fire_ack[1] === 1'b1) early = 1'b1;
            @(negedge CLK);
        end
        #1;
        ack_now = fire_ack[1];
        @(negedge CLK);
        fire_req = 2'b00;
        #1;
        busy_after = busy;
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL busy_len_with_tick: got %0d want 16", n);
        end
        total++;
        if (early !== 1'b0 || ack_now !== 1'b1) begin
            bad++;
            $display("FAIL deferred_ack: early=%b ack_first_idle=%b want 0 1", early, ack_now);
        end
        total++;
        if (busy_after !== 1'b0 || bullet_array[1][0] !== mk(10'd16, 10'd16, 3'd4, L0)) begin
            bad++;
            $display("FAIL deferred_spawn: busy=%b slot=%h want 0 %h", busy_after, bullet_array[1][0],
                     mk(10'd16, 10'd16, 3'd4, L0));
        end
    endtask

    task automatic test_clear();
        logic [1:0] a, d;
        int n;
        do_reset();
        tank2_x = 10'd100; tank2_y = 10'd100; turret2_direction = 3'd2;
        fire(2'b10, a, d);
        @(negedge CLK);
        fire_req = 2'b10;
        clear_mask = 16'h0200;
        @(negedge CLK);
        fire_req = 2'b00;
        clear_mask = 16'h0000;
        total++;
        if (bullet_array[1][1] !== 32'd0 || bullet_array[1][0] !== mk(10'd116, 10'd116, 3'd2, L0)) begin
            bad++;
            $display("FAIL clear_spawn: slot1=%h slot0=%h want 0 %h", bullet_array[1][1],
                     bullet_array[1][0], mk(10'd116, 10'd116, 3'd2, L0));
        end
        @(negedge CLK);
        fire(2'b10, a, d);
        total++;
        if (bullet_array[1][1] !== mk(10'd116, 10'd116, 3'd2, L0)) begin
            bad++;
            $display("FAIL respawn_slot1: got %h want %h", bullet_array[1][1], mk(10'd116, 10'd116, 3'd2, L0));
        end
        @(negedge CLK);
        frame_tick = 1'b1;
        @(negedge CLK);
        frame_tick = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            clear_mask = (n == 10) ? 16'h0200 : 16'h0000;
            @(negedge CLK);
        end
        clear_mask = 16'h0000;
        total++;
        if (bullet_array[1][1] !== 32'd0 || bullet_array[1][0] !== mk(10'd120, 10'd116, 3'd2, L1)) begin
            bad++;
            $display("FAIL clear_update: slot1=%h slot0=%h want 0 %h", bullet_array[1][1],
                     bullet_array[1][0], mk(10'd120, 10'd116, 3'd2, L1));
        end
    endtask

    task automatic test_reset_mid_update();
        logic [1:0] a, d;
        int n;
        do_reset();
        tank1_x = 10'd200; tank1_y = 10'd200; turret1_direction = 3'd0;
        fire(2'b01, a, d);
        @(negedge CLK);
        frame_tick = 1'b1;
        @(negedge CLK);
        frame_tick = 1'b0;
        repeat (5) @(negedge CLK);
        Reset = 1'b1;
        fire_req = 2'b01;
        #1;
        total++;
        if (busy !== 1'b0 || bullet_array !== '0 || fire_ack !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid_update: busy=%b ack=%b array_nonzero=%b want 0 00 0",
                     busy, fire_ack, |bullet_array);
        end
        @(negedge CLK);
        Reset = 1'b0;
        fire_req = 2'b00;
        @(negedge CLK);
        tick(n);
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL post_reset_update: busy cycles %0d want 16", n);
        end
    endtask

`ifdef BULLET_LIFETIME_EN
    task automatic test_lifetime();
        logic [1:0] a, d;
        int n;
        do_reset();
        tank1_x = 10'd100; tank1_y = 10'd384; turret1_direction = 3'd0;
        fire(2'b01, a, d);
        tick(n);
        total++;
        if (bullet_array[0][0] !== mk(10'd116, 10'd396, 3'd0, 5'd2)) begin
            bad++;
            $display("FAIL life_tick1: got %h want %h", bullet_array[0][0], mk(10'd116, 10'd396, 3'd0, 5'd2));
        end
        tick(n);
        total++;
        if (bullet_array[0][0] !== mk(10'd116, 10'd392, 3'd0, 5'd1)) begin
            bad++;
            $display("FAIL life_tick2: got %h want %h", bullet_array[0][0], mk(10'd116, 10'd392, 3'd0, 5'd1));
        end
        tick(n);
        total++;
        if (bullet_array[0][0] !== 32'd0) begin
            bad++;
            $display("FAIL life_tick3: got %h want 0", bullet_array[0][0]);
        end
    endtask
`endif

    initial begin
        Reset = 1'b1;
        frame_tick = 1'b0;
        fire_req = 2'b00;
        clear_mask = 16'd0;
        tank1_x = 10'd0; tank1_y = 10'd0; tank2_x = 10'd0; tank2_y = 10'd0;
        turret1_direction = 3'd0; turret2_direction = 3'd0;
        test_reset();
        test_fire_basic();
        test_pool_full();
        test_offscreen();
        test_both_tanks();
        test_fire_during_update();
        test_clear();
        test_reset_mid_update();
`ifdef BULLET_LIFETIME_EN
        test_lifetime();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
